// File: rtl/qsort_pkg.sv
// qsort_pkg
// Shared types for the quicksort engine.
//   state_t  : engine FSM states
//   range_t  : one pending subrange {lo, hi} held on the range stack
// Index fields are sized for the largest supported DEPTH (1024); users
// narrow them to their own index width.
package qsort_pkg;

    localparam int MAX_IDX_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        POP,
        SCAN,
        PIVOT,
        PUSH,
        UNLOAD
    } state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] lo;
        logic [MAX_IDX_W-1:0] hi;
    } range_t;

endpackage

// File: rtl/qsort_range_stack.sv
// qsort_range_stack
// LIFO of pending sort subranges.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears the pointer only)
//   push, push_data : write a range on top of the stack
//   pop          : discard the top entry (push has priority if both are high)
//   top          : current top entry, valid when empty is low
//   empty        : no entries held
module qsort_range_stack
    import qsort_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  range_t push_data,
    input  logic   pop,
    output range_t top,
    output logic   empty
);

    localparam int PW = $clog2(ENTRIES + 1);

    // Storage is rounded up to a power of two so the pointer indexes it
    // without a width mismatch; only ENTRIES slots are ever occupied.
    range_t           store [2**PW];
    logic [PW-1:0]    sp;

    // Stack pointer: the only reset state of the stack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + PW'(1);
        end else if (pop && sp != '0) begin
            sp <= sp - PW'(1);
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            store[sp] <= push_data;
        end
    end

    assign top   = store[sp - PW'(1)];
    assign empty = (sp == '0);

endmodule

// File: rtl/qsort_engine.sv
// qsort_engine
// In-place quicksort (Lomuto partition) over DEPTH words of DATA_W bits.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   desc                          : 1 = descending, captured with the first load word
//   in_valid/in_ready/in_data     : load stream, DEPTH words
//   out_valid/out_ready/out_data  : unload stream, DEPTH sorted words
//   busy                          : high while sorting (POP/SCAN/PIVOT/PUSH)
//   done                          : one-cycle pulse when sorting completes
//   cmp_count                     : SCAN comparisons of the last sort, present
//                                   only when QSORT_ENGINE_STATS_EN is defined
module qsort_engine
    import qsort_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
`ifdef QSORT_ENGINE_STATS_EN
    ,
    output logic [31:0]       cmp_count
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   TWO      = (ADDR_W + 1)'(2);

    state_t            state, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] load_cnt, unl_cnt;
    logic [ADDR_W-1:0] lo_r, hi_r, i_r, j_r;
    logic              desc_r;
    logic              push_phase;

    logic              in_fire, out_fire, load_last;
    logic              take;
    logic [ADDR_W:0]   len_l, len_r;
    logic              l_ok, r_ok, left_first, push_left;

    logic              stk_push, stk_pop, stk_empty;
    range_t            stk_data, stk_top;
    logic              unused_top_bits;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign load_last = (state == LOAD) && in_fire && (load_cnt == LAST_IDX);

    // Element under scan moves left of the partition point when it orders
    // strictly before the pivot; the pivot sits at hi and is untouched by SCAN.
    assign take = desc_r ? (mem[j_r] > mem[hi_r]) : (mem[j_r] < mem[hi_r]);

    // After PIVOT the pivot rests at i: left part is lo..i-1, right is i+1..hi.
    assign len_l      = {1'b0, i_r} - {1'b0, lo_r};
    assign len_r      = {1'b0, hi_r} - {1'b0, i_r};
    assign l_ok       = (len_l >= TWO);
    assign r_ok       = (len_r >= TWO);
    assign left_first = (len_l >= len_r);

    assign out_data        = mem[unl_cnt];
    assign unused_top_bits = ^stk_top;

    qsort_range_stack #(
        .ENTRIES (ADDR_W + 1)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .push_data (stk_data),
        .pop       (stk_pop),
        .top       (stk_top),
        .empty     (stk_empty)
    );

    // Stack control: the full range is seeded on the last load word; PUSH
    // pushes the larger subrange first so the smaller one is sorted next,
    // taking a second cycle when both halves need further work.
    always_comb begin
        stk_push  = 1'b0;
        stk_data  = '0;
        push_left = 1'b0;
        if (load_last) begin
            stk_push    = 1'b1;
            stk_data.lo = '0;
            stk_data.hi = MAX_IDX_W'(LAST_IDX);
        end else if (state == PUSH && (l_ok || r_ok)) begin
            stk_push = 1'b1;
            if (l_ok && r_ok) begin
                push_left = push_phase ? !left_first : left_first;
            end else begin
                push_left = l_ok;
            end
            if (push_left) begin
                stk_data.lo = MAX_IDX_W'(lo_r);
                stk_data.hi = MAX_IDX_W'(i_r - ONE);
            end else begin
                stk_data.lo = MAX_IDX_W'(i_r + ONE);
                stk_data.hi = MAX_IDX_W'(hi_r);
            end
        end
    end

    assign stk_pop = (state == POP) && !stk_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire) state_next = LOAD;
            LOAD:    if (load_last) state_next = POP;
            POP:     state_next = stk_empty ? UNLOAD : SCAN;
            SCAN:    if (j_r == hi_r - ONE) state_next = PIVOT;
            PIVOT:   state_next = PUSH;
            PUSH:    state_next = (l_ok && r_ok && !push_phase) ? PUSH : POP;
            UNLOAD:  if (out_fire && unl_cnt == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode from the state and are forced low while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (rst_n) begin
            in_ready  = (state == IDLE) || (state == LOAD);
            out_valid = (state == UNLOAD);
            busy      = (state == POP) || (state == SCAN) ||
                        (state == PIVOT) || (state == PUSH);
            done      = (state == POP) && stk_empty;
        end
    end

    // Counters and partition indices.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            unl_cnt    <= '0;
            push_phase <= 1'b0;
            desc_r     <= 1'b0;
            lo_r       <= '0;
            hi_r       <= '0;
            i_r        <= '0;
            j_r        <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_fire) begin
                        load_cnt <= load_cnt + ONE;
                        if (state == IDLE) desc_r <= desc;
                    end
                end
                POP: begin
                    if (!stk_empty) begin
                        lo_r <= ADDR_W'(stk_top.lo);
                        hi_r <= ADDR_W'(stk_top.hi);
                        i_r  <= ADDR_W'(stk_top.lo);
                        j_r  <= ADDR_W'(stk_top.lo);
                    end
                    push_phase <= 1'b0;
                end
                SCAN: begin
                    j_r <= j_r + ONE;
                    if (take) i_r <= i_r + ONE;
                end
                PUSH: begin
                    push_phase <= l_ok && r_ok && !push_phase;
                end
                UNLOAD: begin
                    if (out_fire) unl_cnt <= unl_cnt + ONE;
                end
                default: ;
            endcase
        end
    end

    // Element storage: load writes, SCAN swaps, PIVOT places the pivot.
    always_ff @(posedge clk) begin
        case (state)
            IDLE, LOAD: begin
                if (in_fire) mem[load_cnt] <= in_data;
            end
            SCAN: begin
                if (take) begin
                    mem[i_r] <= mem[j_r];
                    mem[j_r] <= mem[i_r];
                end
            end
            PIVOT: begin
                mem[i_r]  <= mem[hi_r];
                mem[hi_r] <= mem[i_r];
            end
            default: ;
        endcase
    end

`ifdef QSORT_ENGINE_STATS_EN
    // Comparison statistics: restart when a new sort begins, saturate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_count <= '0;
        end else if (load_last) begin
            cmp_count <= '0;
        end else if (state == SCAN && cmp_count != '1) begin
            cmp_count <= cmp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qsort_engine.sv
// tb_qsort_engine
// Self-checking bench for qsort_engine at DEPTH=8, DATA_W=32.
// Define QSORT_ENGINE_STATS_EN to also exercise cmp_count.
module tb_qsort_engine;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int SORT_BOUND = N * (N + 3);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          desc;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
`ifdef QSORT_ENGINE_STATS_EN
    logic [31:0]   cmp_count;
`endif

    always #5 clk = ~clk;

    qsort_engine #(
        .DATA_W (DW),
        .DEPTH  (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .desc      (desc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
`ifdef QSORT_ENGINE_STATS_EN
        ,
        .cmp_count (cmp_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] data [N];
        logic [DW-1:0] exp  [N];
        bit            desc;
        bit            rand_ready;
        int            exp_cmp;
    } vec_t;

    vec_t          vecs [6];
    logic [DW-1:0] sb_q [$];
    int            checks;
    int            errors;

    // Single comparison point: every check counts here.
    task automatic checkValue(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Load one vector; desc is valid only with the first word and inverted
    // afterwards, and random bubbles are inserted in in_valid.
    task automatic applyStimulus(input int idx, input bit to_sb);
        int k = 0;
        int guard = 0;
        if (to_sb) for (int e = 0; e < N; e++) sb_q.push_back(vecs[idx].exp[e]);
        while (k < N && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = (k == 0) || ($urandom_range(0, 3) != 0);
            in_data  = vecs[idx].data[k];
            desc     = (k == 0) ? vecs[idx].desc : !vecs[idx].desc;
            if (in_valid && in_ready) k++;
        end
        checkValue("load_words_accepted", DW'(k), DW'(N));
    endtask

    // Wait for the sort to finish while pushing junk on the load port.
    task automatic runSort(input int idx);
        int cycles = 0;
        int dones = 0;
        int ready_bad = 0;
        int guard = 0;
        bit seen = 0;
        while (!seen && guard < SORT_BOUND + 10) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                seen = 1;
            end else begin
                in_valid = 1'b1;
                in_data  = 32'h0BAD_0BAD;
                if (busy) cycles++;
                if (done) dones++;
                if (busy && in_ready) ready_bad++;
            end
        end
        in_valid = 1'b0;
        checkValue("sort_reached_unload", DW'(seen), 1);
        checkValue("done_pulses", DW'(dones), 1);
        checkValue("sort_cycles_in_bound", DW'(cycles <= SORT_BOUND), 1);
        checkValue("in_ready_low_while_busy", DW'(ready_bad), 0);
        checkValue("busy_low_in_unload", DW'(busy), 0);
`ifdef QSORT_ENGINE_STATS_EN
        if (vecs[idx].exp_cmp >= 0)
            checkValue("cmp_count", cmp_count, DW'(vecs[idx].exp_cmp));
`endif
    endtask

    // Drain the unload stream against the scoreboard, optionally stalling.
    task automatic checkOutput(input int idx);
        int got = 0;
        int guard = 0;
        bit prev_stall = 0;
        bit rdy;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] want;
        while (got < N && guard < 200) begin
            @(negedge clk);
            guard++;
            if (!out_valid) begin
                checkValue("out_valid_during_unload", DW'(out_valid), 1);
                guard = 200;
            end else begin
                if (prev_stall) checkValue("stall_data_stable", out_data, prev_data);
                rdy = vecs[idx].rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    want = sb_q.pop_front();
                    checkValue($sformatf("vec%0d_out%0d", idx, got), out_data, want);
                    got++;
                end
                prev_stall = !rdy;
                prev_data  = out_data;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        checkValue("unload_word_count", DW'(got), DW'(N));
        checkValue("out_valid_after_unload", DW'(out_valid), 0);
        checkValue("idle_in_ready_after_unload", DW'(in_ready), 1);
        checkValue("scoreboard_empty", DW'(sb_q.size()), 0);
`ifdef QSORT_ENGINE_STATS_EN
        if (vecs[idx].exp_cmp >= 0)
            checkValue("cmp_count_held_idle", cmp_count, DW'(vecs[idx].exp_cmp));
`endif
    endtask

    // Abort a sort with a one-cycle reset in the middle of the first SCAN.
    task automatic resetDuringScan();
        int guard = 0;
        int dones = 0;
        applyStimulus(0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        while (!busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkValue("busy_after_load", DW'(busy), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checkValue("rst_busy", DW'(busy), 0);
        checkValue("rst_in_ready", DW'(in_ready), 0);
        checkValue("rst_done", DW'(done), 0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkValue("abort_busy_low", DW'(busy), 0);
        checkValue("abort_idle_ready", DW'(in_ready), 1);
        checkValue("abort_out_valid_low", DW'(out_valid), 0);
        checkValue("abort_no_done", DW'(dones), 0);
`ifdef QSORT_ENGINE_STATS_EN
        checkValue("abort_cmp_count_reset", cmp_count, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0].data = '{5, 3, 8, 1, 7, 2, 6, 4};
        vecs[0].exp  = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[0].desc = 0; vecs[0].rand_ready = 0; vecs[0].exp_cmp = -1;

        vecs[1].data = '{5, 3, 8, 1, 7, 2, 6, 4};
        vecs[1].exp  = '{8, 7, 6, 5, 4, 3, 2, 1};
        vecs[1].desc = 1; vecs[1].rand_ready = 0; vecs[1].exp_cmp = -1;

        vecs[2].data = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[2].exp  = '{1, 2, 3, 4, 5, 6, 7, 8};
        vecs[2].desc = 0; vecs[2].rand_ready = 0; vecs[2].exp_cmp = 28;

        vecs[3].data = '{8{32'hA5}};
        vecs[3].exp  = '{8{32'hA5}};
        vecs[3].desc = 0; vecs[3].rand_ready = 0; vecs[3].exp_cmp = 28;

        vecs[4].data = '{32'hDEADBEEF, 0, 32'hFFFFFFFF, 12, 7, 32'h80000000, 9, 3};
        vecs[4].exp  = '{0, 3, 7, 9, 12, 32'h80000000, 32'hDEADBEEF, 32'hFFFFFFFF};
        vecs[4].desc = 0; vecs[4].rand_ready = 1; vecs[4].exp_cmp = -1;

        vecs[5].data = '{2, 9, 4, 4, 1, 0, 6, 3};
        vecs[5].exp  = '{9, 6, 4, 4, 3, 2, 1, 0};
        vecs[5].desc = 1; vecs[5].rand_ready = 1; vecs[5].exp_cmp = -1;

        rst_n     = 1'b0;
        desc      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkValue("reset_in_ready", DW'(in_ready), 0);
        checkValue("reset_out_valid", DW'(out_valid), 0);
        checkValue("reset_busy", DW'(busy), 0);
        checkValue("reset_done", DW'(done), 0);
`ifdef QSORT_ENGINE_STATS_EN
        checkValue("reset_cmp_count", cmp_count, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("idle_in_ready", DW'(in_ready), 1);

        resetDuringScan();

        for (int v = 0; v < 6; v++) begin
            applyStimulus(v, 1'b1);
            runSort(v);
            checkOutput(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
